// File: rtl/bus_dma_copier.sv
// bus_dma_copier: bus initiator that copies a block of 32-bit words from a
// source region to a destination region, one read followed by one write per word.
//
// Optional feature macro: BUS_DMA_COPIER_FILL_EN
//   When defined, adds fill/fill_value. A start with fill=1 skips the reads and
//   writes fill_value to count consecutive words (one bus cycle per word).
//
// Ports
//   clk          clock
//   reset        synchronous reset, active-low (0 = reset)
//   start        one-cycle request, sampled only while idle
//   src_addr     source byte address (bits [1:0] forced to 0)
//   dst_addr     destination byte address (bits [1:0] forced to 0)
//   count        number of words to copy (0 = immediate done)
//   abort        level, evaluated at each write handshake
//   fill         (FILL_EN only) fill mode select, sampled with start
//   fill_value   (FILL_EN only) word written in fill mode
//   busy         high from the cycle after an accepted start until the final handshake
//   done         one-cycle pulse after the transfer ends
//   bus_valid    transaction request
//   bus_ready    responder completes the transaction this cycle
//   bus_address  word-aligned byte address
//   bus_wstrobe  4'b0000 = read, 4'b1111 = full-word write
//   bus_wdata    write data
//   bus_rdata    read data, valid on a read handshake

module bus_dma_copier #(
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [31:0]            src_addr,
   input  logic [31:0]            dst_addr,
   input  logic [COUNT_WIDTH-1:0] count,
   input  logic                   abort,
`ifdef BUS_DMA_COPIER_FILL_EN
   input  logic                   fill,
   input  logic [31:0]            fill_value,
`endif
   output logic                   busy,
   output logic                   done,
   output logic                   bus_valid,
   input  logic                   bus_ready,
   output logic [31:0]            bus_address,
   output logic [3:0]             bus_wstrobe,
   output logic [31:0]            bus_wdata,
   input  logic [31:0]            bus_rdata
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_READ   = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [ADDR_W-1:0]      src_q, src_d;
   logic [ADDR_W-1:0]      dst_q, dst_d;
   logic [COUNT_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_W-1:0]      data_q, data_d;

   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   bus_valid_q, bus_valid_d;
   logic [ADDR_W-1:0]      bus_address_q, bus_address_d;
   logic [STRB_W-1:0]      bus_wstrobe_q, bus_wstrobe_d;
   logic [DATA_W-1:0]      bus_wdata_q, bus_wdata_d;

   // Fill-mode flag: a real register only when the feature is built in.
`ifdef BUS_DMA_COPIER_FILL_EN
   logic                   fill_q, fill_d;
`else
   logic                   fill_q;
   assign fill_q = 1'b0;
`endif

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      dst_d         = dst_q;
      rem_d         = rem_q;
      data_d        = data_q;
`ifdef BUS_DMA_COPIER_FILL_EN
      fill_d        = fill_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d = {src_addr[ADDR_W-1:2], 2'b00};
               dst_d = {dst_addr[ADDR_W-1:2], 2'b00};
               rem_d = count;
`ifdef BUS_DMA_COPIER_FILL_EN
               fill_d = fill;
               if (count == '0) begin
                  state_d = S_FINISH;
               end else if (fill) begin
                  data_d  = fill_value;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
`else
               state_d = (count == '0) ? S_FINISH : S_READ;
`endif
            end
         end
         S_READ: begin
            if (bus_ready) begin
               data_d  = bus_rdata;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (bus_ready) begin
               src_d = src_q + ADDR_W'(4);
               dst_d = dst_q + ADDR_W'(4);
               rem_d = rem_q - COUNT_WIDTH'(1);
               // Abort and end-of-block are only honoured at a write handshake.
               if ((rem_q == COUNT_WIDTH'(1)) || abort) begin
                  state_d = S_FINISH;
               end else if (fill_q) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are derived from the next state so they line up with it once registered.
      bus_valid_d   = (state_d == S_READ) || (state_d == S_WRITE);
      busy_d        = bus_valid_d;
      done_d        = (state_d == S_FINISH);
      bus_address_d = bus_address_q;
      bus_wstrobe_d = '0;
      bus_wdata_d   = bus_wdata_q;
      if (state_d == S_READ) begin
         bus_address_d = src_d;
      end else if (state_d == S_WRITE) begin
         bus_address_d = dst_d;
         bus_wstrobe_d = {STRB_W{1'b1}};
         bus_wdata_d   = data_d;
      end
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         src_q         <= '0;
         dst_q         <= '0;
         rem_q         <= '0;
         data_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         bus_valid_q   <= 1'b0;
         bus_address_q <= '0;
         bus_wstrobe_q <= '0;
         bus_wdata_q   <= '0;
`ifdef BUS_DMA_COPIER_FILL_EN
         fill_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         dst_q         <= dst_d;
         rem_q         <= rem_d;
         data_q        <= data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         bus_valid_q   <= bus_valid_d;
         bus_address_q <= bus_address_d;
         bus_wstrobe_q <= bus_wstrobe_d;
         bus_wdata_q   <= bus_wdata_d;
`ifdef BUS_DMA_COPIER_FILL_EN
         fill_q        <= fill_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign bus_valid   = bus_valid_q;
   assign bus_address = bus_address_q;
   assign bus_wstrobe = bus_wstrobe_q;
   assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_bus_dma_copier.sv
// Bench for bus_dma_copier: table of directed transfers plus random transfers,
// all checked against a word-level copy model and a memory-backed bus responder.

module tb_bus_dma_copier;

   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [31:0]   src_addr;
   logic [31:0]   dst_addr;
   logic [CW-1:0] count;
   logic          abort;
`ifdef BUS_DMA_COPIER_FILL_EN
   logic          fill;
   logic [31:0]   fill_value;
`endif
   logic          busy;
   logic          done;
   logic          bus_valid;
   logic          bus_ready = 1'b0;
   logic [31:0]   bus_address;
   logic [3:0]    bus_wstrobe;
   logic [31:0]   bus_wdata;
   logic [31:0]   bus_rdata = 32'h0;

   always #5 clk = ~clk;

   bus_dma_copier #(.COUNT_WIDTH(CW)) dut (
      .clk         (clk),
      .reset       (reset_n),
      .start       (start),
      .src_addr    (src_addr),
      .dst_addr    (dst_addr),
      .count       (count),
      .abort       (abort),
`ifdef BUS_DMA_COPIER_FILL_EN
      .fill        (fill),
      .fill_value  (fill_value),
`endif
      .busy        (busy),
      .done        (done),
      .bus_valid   (bus_valid),
      .bus_ready   (bus_ready),
      .bus_address (bus_address),
      .bus_wstrobe (bus_wstrobe),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } hs_t;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          cnt;
      bit          fill;
      logic [31:0] fval;
      int          abort_word;
      bit          abort_at_start;
      bit          poke_start;
      int          stall;
      int          exp_hs;
      int          exp_lat;
   } vec_t;

   int vectors     = 0;
   int miscompares = 0;

   // Responder state (owned by the negedge responder process).
   logic [31:0] mem [logic [31:0]];
   hs_t         hs_log[$];
   int          stall_max = 0;
   int          wait_cnt  = 0;
   int          stab_err  = 0;
   bit          s_valid = 1'b0, s_ready = 1'b0;
   logic [31:0] s_addr = '0, s_wd = '0, s_rd = '0;
   logic [3:0]  s_ws = '0;
   hs_t         mon_e;

   // Reference-model state (owned by the main sequence).
   logic [31:0] ref_mem [logic [31:0]];
   hs_t         exp_q[$];

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : pat(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : pat(a);
   endfunction

   // Bus responder: the snapshot taken at the previous negedge is what the DUT
   // saw at the intervening posedge, so it tells whether a handshake happened.
   always @(negedge clk) begin
      if (s_valid && s_ready) begin
         mon_e.we   = (s_ws != 4'h0);
         mon_e.addr = s_addr;
         mon_e.data = (s_ws != 4'h0) ? s_wd : s_rd;
         hs_log.push_back(mon_e);
         if (s_ws != 4'h0) mem[s_addr] = s_wd;
      end else if (s_valid) begin
         if (!(bus_valid && bus_address == s_addr && bus_wstrobe == s_ws &&
               (s_ws == 4'h0 || bus_wdata == s_wd)))
            stab_err++;
      end
      if ((s_valid && s_ready) || !bus_valid)
         wait_cnt = int'($urandom_range(0, 32'(stall_max)));
      if (bus_valid) begin
         if (wait_cnt == 0) bus_ready = 1'b1;
         else begin
            bus_ready = 1'b0;
            wait_cnt--;
         end
      end else begin
         bus_ready = 1'($urandom);
      end
      bus_rdata = (bus_valid && bus_wstrobe == 4'h0) ? mem_rd(bus_address) : $urandom;
      s_valid = bus_valid;
      s_ready = bus_ready;
      s_addr  = bus_address;
      s_ws    = bus_wstrobe;
      s_wd    = bus_wdata;
      s_rd    = bus_rdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                               input int stall, input int aw, input int exp_hs, input int exp_lat);
      vec_t v;
      v.src = src; v.dst = dst; v.cnt = cnt; v.stall = stall; v.abort_word = aw;
      v.fill = 1'b0; v.fval = '0; v.abort_at_start = 1'b0; v.poke_start = 1'b0;
      v.exp_hs = exp_hs; v.exp_lat = exp_lat;
      return v;
   endfunction

   // Apply one transfer and check it against the word-level model.
   task automatic run_vec(input string tag, input vec_t v);
      logic [31:0] sa, da, a, trig, d;
      int          aw, words, base, cyc, budget, stab0, n, nexp;
      bit          busy_seen, timed_out;
      hs_t         e;

      sa = {v.src[31:2], 2'b00};
      da = {v.dst[31:2], 2'b00};
      aw = v.abort_at_start ? 0 : v.abort_word;
      if (aw >= v.cnt) aw = -1;
      words = (aw >= 0) ? aw + 1 : v.cnt;

      // Model: ascending word copy (or fill), stopping after the aborted word.
      exp_q.delete();
      for (int i = 0; i < words; i++) begin
         a = da + 32'(4 * i);
         if (v.fill) d = v.fval;
         else begin
            d = ref_rd(sa + 32'(4 * i));
            e.we = 1'b0; e.addr = sa + 32'(4 * i); e.data = d;
            exp_q.push_back(e);
         end
         e.we = 1'b1; e.addr = a; e.data = d;
         exp_q.push_back(e);
         ref_mem[a] = d;
      end
      trig = v.fill ? da + 32'(4 * aw) : sa + 32'(4 * aw);
      nexp = (v.exp_hs >= 0) ? v.exp_hs : exp_q.size();

      stall_max = v.stall;
      @(negedge clk);
      base  = hs_log.size();
      stab0 = stab_err;
      start = 1'b1; src_addr = v.src; dst_addr = v.dst; count = CW'(v.cnt);
      abort = v.abort_at_start;
`ifdef BUS_DMA_COPIER_FILL_EN
      fill = v.fill; fill_value = v.fval;
`endif
      @(negedge clk);
      cyc = 1; busy_seen = 1'b0; timed_out = 1'b0;
      budget = 60 + v.cnt * 2 * (v.stall + 2);
      while (1) begin
         if (busy) busy_seen = 1'b1;
         if (v.poke_start && cyc == 3) begin
            start = 1'b1; src_addr = 32'h0000_9000; dst_addr = 32'h0000_9800; count = CW'(5);
         end else begin
            start = 1'b0;
         end
         if (aw >= 0 && bus_valid && bus_address == trig &&
             (v.fill ? (bus_wstrobe == 4'hF) : (bus_wstrobe == 4'h0)))
            abort = 1'b1;
         if (done) break;
         if (cyc >= budget) begin
            timed_out = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      abort = 1'b0; start = 1'b0;

      if (timed_out) begin
         vectors++; miscompares++;
         $display("FAIL %s done_timeout: got no done after %0d cycles expected done", tag, cyc);
         reset_n = 1'b0;
         repeat (2) @(negedge clk);
         reset_n = 1'b1;
         return;
      end
      if (v.exp_lat >= 0) chk({tag, " done_latency"}, 32'(cyc), 32'(v.exp_lat));
      chk({tag, " busy_at_done"}, 32'(busy), 32'h0);
      chk({tag, " valid_at_done"}, 32'(bus_valid), 32'h0);
      @(negedge clk);
      chk({tag, " done_width"}, 32'(done), 32'h0);
      chk({tag, " busy_seen"}, 32'(busy_seen), 32'(v.cnt != 0));
      @(negedge clk);
      n = hs_log.size() - base;
      chk({tag, " hs_count"}, 32'(n), 32'(nexp));
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         chk($sformatf("%s hs%0d_kind", tag, i), 32'(hs_log[base + i].we), 32'(exp_q[i].we));
         chk($sformatf("%s hs%0d_addr", tag, i), hs_log[base + i].addr, exp_q[i].addr);
         chk($sformatf("%s hs%0d_data", tag, i), hs_log[base + i].data, exp_q[i].data);
      end
      for (int i = 0; i <= v.cnt; i++) begin
         a = da + 32'(4 * i);
         chk($sformatf("%s dst_word%0d", tag, i), mem_rd(a), ref_rd(a));
      end
      chk({tag, " stall_stable"}, 32'(stab_err - stab0), 32'h0);
   endtask

   vec_t vt[$];
   vec_t rv;

   initial begin
      int dn, vn;
      reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; count = '0; abort = 1'b0;
`ifdef BUS_DMA_COPIER_FILL_EN
      fill = 1'b0; fill_value = '0;
`endif
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset done", 32'(done), 32'h0);
      chk("reset valid", 32'(bus_valid), 32'h0);
      chk("reset address", bus_address, 32'h0);
      chk("reset wstrobe", 32'(bus_wstrobe), 32'h0);
      chk("reset wdata", bus_wdata, 32'h0);
      reset_n = 1'b1;
      // Abort while idle must not start or disturb anything.
      abort = 1'b1;
      repeat (3) @(negedge clk);
      abort = 1'b0;
      chk("idle_abort busy", 32'(busy), 32'h0);

      // Directed table: {src, dst, count, stall, abort_word, handshakes, done latency}.
      vt.push_back(mk(32'h0000_0100, 32'h0000_0200, 4, 0, -1, 8, 9));
      vt.push_back(mk(32'h0000_1000, 32'h0000_2000, 16, 5, -1, 32, -1));
      vt.push_back(mk(32'h0000_0300, 32'h0000_0400, 0, 0, -1, 0, 1));
      vt.push_back(mk(32'h0000_0500, 32'h0000_0600, 8, 0, 1, 4, 5));
      vt.push_back(mk(32'hFFFF_FFF8, 32'h0000_0700, 4, 0, -1, 8, 9));
      vt.push_back(mk(32'h0000_0103, 32'h0000_020A, 2, 0, -1, 4, 5));
      vt.push_back(mk(32'h0000_0900, 32'hFFFF_FFFC, 3, 2, -1, 6, -1));
      rv = mk(32'h0000_0A00, 32'h0000_0B00, 2, 0, -1, 4, 5); rv.poke_start = 1'b1;
      vt.push_back(rv);
      rv = mk(32'h0000_0C00, 32'h0000_0D00, 3, 0, -1, 2, 3); rv.abort_at_start = 1'b1;
      vt.push_back(rv);
      vt.push_back(mk(32'h0000_0E00, 32'h0000_0E04, 4, 1, -1, 8, -1));
`ifdef BUS_DMA_COPIER_FILL_EN
      rv = mk(32'h0000_3000, 32'h0000_0040, 3, 0, -1, 3, 4);
      rv.fill = 1'b1; rv.fval = 32'hDEAD_BEEF;
      vt.push_back(rv);
      rv = mk(32'h0000_3000, 32'h0000_0080, 5, 0, 1, 2, 3);
      rv.fill = 1'b1; rv.fval = 32'h1234_5678;
      vt.push_back(rv);
`endif
      foreach (vt[i]) run_vec($sformatf("vec%0d", i), vt[i]);

      // Random transfers against the model.
      for (int r = 0; r < 30; r++) begin
         rv.src = $urandom;
         rv.dst = ($urandom_range(0, 3) == 0) ? rv.src + 32'($urandom_range(0, 8) * 4) : $urandom;
         rv.cnt = int'($urandom_range(0, 10));
         rv.stall = int'($urandom_range(0, 3));
         rv.abort_word = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
         rv.abort_at_start = 1'b0;
         rv.poke_start = 1'b0;
         rv.fill = 1'b0;
         rv.fval = $urandom;
`ifdef BUS_DMA_COPIER_FILL_EN
         rv.fill = ($urandom_range(0, 3) == 0);
`endif
         rv.exp_hs = -1;
         rv.exp_lat = -1;
         if (rv.stall == 0) begin
            if (rv.cnt == 0) rv.exp_lat = 1;
            else begin
               vn = (rv.abort_word >= 0 && rv.abort_word < rv.cnt) ? rv.abort_word + 1 : rv.cnt;
               rv.exp_lat = (rv.fill ? vn : 2 * vn) + 1;
            end
         end
         run_vec($sformatf("rnd%0d", r), rv);
      end

      // Reset in the middle of a transfer drops the request and never pulses done.
      stall_max = 0;
      repeat (2) @(negedge clk);
      start = 1'b1; src_addr = 32'h0000_7000; dst_addr = 32'h0000_7800; count = CW'(8);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("midreset valid_before", 32'(bus_valid), 32'h1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midreset valid", 32'(bus_valid), 32'h0);
      chk("midreset busy", 32'(busy), 32'h0);
      chk("midreset done", 32'(done), 32'h0);
      chk("midreset address", bus_address, 32'h0);
      chk("midreset wstrobe", 32'(bus_wstrobe), 32'h0);
      chk("midreset wdata", bus_wdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      dn = 0; vn = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dn++;
         if (bus_valid) vn++;
      end
      chk("midreset done_after", 32'(dn), 32'h0);
      chk("midreset valid_after", 32'(vn), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1);
   end

endmodule
